// File: rtl/song_sequencer_pkg.sv
// song_sequencer_pkg
// Shared definitions for the song sequencer: sequencer states, special note
// codes, rom_data field positions, the duration counter width, and helpers
// that turn a raw note code into what the buzzer and the LEDs should see.
// rom_data layout: {note[3:0], octave[1:0], dur[3:0]}.

package song_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP
    } state_t;

    localparam logic [3:0] NOTE_REST = 4'h0;
    localparam logic [3:0] NOTE_END  = 4'hF;

    localparam int NOTE_MSB = 9;
    localparam int NOTE_LSB = 6;
    localparam int OCT_MSB  = 5;
    localparam int OCT_LSB  = 4;
    localparam int DUR_MSB  = 3;
    localparam int DUR_LSB  = 0;

    // dur (4 bits) times BEAT_MS is held without truncation
    localparam int MS_CNT_W = 16;

    // Only do..si (1..7) reach the buzzer; rests and codes 8..14 are silence
    function automatic logic [3:0] audibleNote(input logic [3:0] code);
        return (code >= 4'd1 && code <= 4'd7) ? code : NOTE_REST;
    endfunction

    // One-hot LED pattern, bit (note-1) for a sounding note
    function automatic logic [6:0] noteToLed(input logic [3:0] code);
        logic [6:0] led;
        led = '0;
        if (code >= 4'd1 && code <= 4'd7) begin
            led[code[2:0] - 3'd1] = 1'b1;
        end
        return led;
    endfunction

endpackage

// File: rtl/song_sequencer_ms_tick.sv
// song_sequencer_ms_tick
// Millisecond prescaler: divides clk by CLK_HZ/1000 and emits a one-cycle
// tick at the end of every millisecond. A synchronous clear restarts the
// millisecond so that the first tick comes a full millisecond later.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high reset
//   clr_i  in  restart the current millisecond
//   tick_o out one-cycle pulse in the last cycle of each millisecond

module song_sequencer_ms_tick #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);

    localparam int DIV   = CLK_HZ / 1000;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q + 1'b1;
        if (clr_i || count_q == LAST) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = (count_q == LAST);

endmodule

// File: rtl/song_sequencer.sv
// song_sequencer
// Auto-play scheduler for the buzzer path. Walks the song ROM one note at a
// time (FETCH, LOAD), sounds each note for dur*BEAT_MS ms (PLAY), then keeps a
// silent gap of GAP_MS ms (GAP). Also selects the song with next/prev pulses.
// A play pulse sampled at edge k starts FETCH at edge k+1, so the first note
// is heard from edge k+3.
// Optional build macro: LOOP_EN -- when defined, the end of a song restarts it
// from note 0 instead of returning to IDLE.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   enable                auto mode active
//   play                  one-cycle pulse, start the selected song
//   song_next, song_prev  one-cycle pulses, select next/previous song
//   rom_addr              {song_idx, note_ptr}
//   rom_data              {note, octave, dur}, valid one cycle after rom_addr
//   note_out, octave_out  to the buzzer (note 0 = silence)
//   led_out               one-hot LED for the sounding note
//   num                   song_idx+1 for the 7-segment display
//   busy                  high whenever not IDLE

module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BEAT_MS   = 125,
    parameter int GAP_MS    = 20,
    parameter int NUM_SONGS = 3,
    parameter int ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              play,
    input  logic              song_next,
    input  logic              song_prev,
    output logic [ADDR_W+1:0] rom_addr,
    input  logic [9:0]        rom_data,
    output logic [3:0]        note_out,
    output logic [1:0]        octave_out,
    output logic [6:0]        led_out,
    output logic [3:0]        num,
    output logic              busy
);

`ifdef LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    localparam logic [1:0]          LAST_SONG  = 2'(NUM_SONGS - 1);
    localparam logic [MS_CNT_W-1:0] GAP_TARGET = MS_CNT_W'(GAP_MS);

    state_t                state_q, state_d;
    logic [1:0]            songIdx_q, songIdx_d;
    logic [ADDR_W-1:0]     notePtr_q, notePtr_d;
    logic                  startPending_q, startPending_d;
    logic [MS_CNT_W-1:0]   durTarget_q, durTarget_d;
    logic [MS_CNT_W-1:0]   msCnt_q, msCnt_d;
    logic [3:0]            noteOut_q, noteOut_d;
    logic [1:0]            octOut_q, octOut_d;
    logic [6:0]            led_q, led_d;
    logic                  msTick, msClear;
    logic                  songChange;
    logic [3:0]            romNote;
    logic [1:0]            romOct;
    logic [3:0]            romDur, durEff;

    assign romNote    = rom_data[NOTE_MSB:NOTE_LSB];
    assign romOct     = rom_data[OCT_MSB:OCT_LSB];
    assign romDur     = rom_data[DUR_MSB:DUR_LSB];
    assign durEff     = (romDur == 4'd0) ? 4'd1 : romDur;
    // Simultaneous next and prev cancel each other
    assign songChange = song_next ^ song_prev;

    song_sequencer_ms_tick #(
        .CLK_HZ(CLK_HZ)
    ) u_msTick (
        .clk   (clk),
        .reset (reset),
        .clr_i (msClear),
        .tick_o(msTick)
    );

    always_comb begin
        state_d        = state_q;
        songIdx_d      = songIdx_q;
        notePtr_d      = notePtr_q;
        startPending_d = 1'b0;
        durTarget_d    = durTarget_q;
        noteOut_d      = noteOut_q;
        octOut_d       = octOut_q;
        led_d          = led_q;
        msCnt_d        = msCnt_q;

        if (!enable) begin
            state_d   = S_IDLE;
            notePtr_d = '0;
        end else if (songChange) begin
            // A song change always aborts and drops any pending play
            if (song_next) begin
                songIdx_d = (songIdx_q == LAST_SONG) ? 2'd0 : songIdx_q + 2'd1;
            end else begin
                songIdx_d = (songIdx_q == 2'd0) ? LAST_SONG : songIdx_q - 2'd1;
            end
            state_d   = S_IDLE;
            notePtr_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    notePtr_d = '0;
                    if (startPending_q) begin
                        state_d = S_FETCH;
                    end else if (play) begin
                        startPending_d = 1'b1;
                    end
                end
                S_FETCH: begin
                    state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (romNote == NOTE_END) begin
                        state_d   = LOOP ? S_FETCH : S_IDLE;
                        notePtr_d = '0;
                    end else begin
                        state_d     = S_PLAY;
                        durTarget_d = MS_CNT_W'(durEff) * MS_CNT_W'(BEAT_MS);
                        noteOut_d   = audibleNote(romNote);
                        octOut_d    = romOct;
                        led_d       = noteToLed(romNote);
                    end
                end
                S_PLAY: begin
                    if (msTick && (msCnt_q + 1'b1) == durTarget_q) begin
                        state_d   = S_GAP;
                        noteOut_d = NOTE_REST;
                        led_d     = '0;
                    end
                end
                S_GAP: begin
                    if (msTick && (msCnt_q + 1'b1) == GAP_TARGET) begin
                        if (&notePtr_q) begin
                            // Last address of the song finished: implicit end
                            state_d   = LOOP ? S_FETCH : S_IDLE;
                            notePtr_d = '0;
                        end else begin
                            state_d   = S_FETCH;
                            notePtr_d = notePtr_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        if (state_d == S_IDLE) begin
            noteOut_d = NOTE_REST;
            octOut_d  = '0;
            led_d     = '0;
        end

        // Both the prescaler and the ms count restart on entry to PLAY or GAP
        msClear = (state_d == S_PLAY && state_q != S_PLAY) ||
                  (state_d == S_GAP  && state_q != S_GAP);
        if (msClear) begin
            msCnt_d = '0;
        end else if (msTick && (state_q == S_PLAY || state_q == S_GAP)) begin
            msCnt_d = msCnt_q + 1'b1;
        end
    end

    // Outputs are registered from next-state values so they change on the
    // same edge as the state itself
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            songIdx_q      <= 2'd0;
            notePtr_q      <= '0;
            startPending_q <= 1'b0;
            durTarget_q    <= '0;
            msCnt_q        <= '0;
            noteOut_q      <= '0;
            octOut_q       <= '0;
            led_q          <= '0;
            rom_addr       <= '0;
            num            <= 4'd1;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            songIdx_q      <= songIdx_d;
            notePtr_q      <= notePtr_d;
            startPending_q <= startPending_d;
            durTarget_q    <= durTarget_d;
            msCnt_q        <= msCnt_d;
            noteOut_q      <= noteOut_d;
            octOut_q       <= octOut_d;
            led_q          <= led_d;
            rom_addr       <= {songIdx_d, notePtr_d};
            num            <= {2'b00, songIdx_d} + 4'd1;
            busy           <= (state_d != S_IDLE);
        end
    end

    assign note_out   = noteOut_q;
    assign octave_out = octOut_q;
    assign led_out    = led_q;

endmodule

// File: tb/tb_song_sequencer.sv
// tb_song_sequencer
// Bench for song_sequencer at CLK_HZ=4000 (1 ms = 4 cycles), BEAT_MS=2,
// GAP_MS=1. A behavioural model expands each started song into a queue of
// per-cycle expected outputs from the note list; a compare process checks the
// DUT against it every cycle. Directed literal checks pin key timing points.

module tb_song_sequencer;

    localparam int CLK_HZ    = 4000;
    localparam int BEAT_MS   = 2;
    localparam int GAP_MS    = 1;
    localparam int NUM_SONGS = 3;
    localparam int ADDR_W    = 6;
    localparam int CYC_MS    = CLK_HZ / 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       play = 1'b0;
    logic       song_next = 1'b0;
    logic       song_prev = 1'b0;
    logic [7:0] rom_addr;
    logic [9:0] rom_data = '0;
    logic [3:0] note_out;
    logic [1:0] octave_out;
    logic [6:0] led_out;
    logic [3:0] num;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int edgeCnt = 0;
    int playEdge = 0;

    always #5 clk = ~clk;

    song_sequencer #(
        .CLK_HZ   (CLK_HZ),
        .BEAT_MS  (BEAT_MS),
        .GAP_MS   (GAP_MS),
        .NUM_SONGS(NUM_SONGS),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .play      (play),
        .song_next (song_next),
        .song_prev (song_prev),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .note_out  (note_out),
        .octave_out(octave_out),
        .led_out   (led_out),
        .num       (num),
        .busy      (busy)
    );

    // Synchronous song ROM: data valid one cycle after the address
    logic [9:0] romMem [0:255];
    always @(posedge clk) rom_data <= romMem[rom_addr];

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [3:0] note;
        logic [1:0] oct;
        logic       busy;
        logic [7:0] addr;
    } expect_t;

    expect_t    expQ[$];
    expect_t    cur;
    logic [1:0] mIdx = 2'd0;
    logic [1:0] mOct = 2'd0;
    bit         mLooping = 1'b0;
    bit         armed = 1'b0;

    function automatic expect_t mk(input logic [3:0] n, input logic [1:0] o,
                                   input logic b, input logic [1:0] idx, input int ptr);
        expect_t e;
        e.note = n;
        e.oct  = o;
        e.busy = b;
        e.addr = {idx, 6'(ptr)};
        return e;
    endfunction

    function automatic void endOfSong(input logic [1:0] idx);
`ifdef LOOP_EN
        repeat (2) expQ.push_back(mk(4'd0, mOct, 1'b1, idx, 0));
        mLooping = 1'b1;
`else
        mLooping = 1'b0;
        if (idx > 2'd3) mLooping = 1'b0;
`endif
    endfunction

    // Expand a whole song, starting at its first PLAY cycle
    function automatic void buildNotes(input logic [1:0] idx);
        logic [9:0] w;
        logic [3:0] code;
        int         nd;
        for (int p = 0; p < 64; p++) begin
            w    = romMem[int'(idx) * 64 + p];
            code = w[9:6];
            if (code == 4'hF) begin
                endOfSong(idx);
                return;
            end
            mOct = w[5:4];
            nd   = (w[3:0] == 4'd0) ? 1 : int'(w[3:0]);
            repeat (nd * BEAT_MS * CYC_MS)
                expQ.push_back(mk((code >= 4'd1 && code <= 4'd7) ? code : 4'd0, mOct, 1'b1, idx, p));
            repeat (GAP_MS * CYC_MS) expQ.push_back(mk(4'd0, mOct, 1'b1, idx, p));
            if (p == 63) begin
                endOfSong(idx);
                return;
            end
            repeat (2) expQ.push_back(mk(4'd0, mOct, 1'b1, idx, p + 1));
        end
    endfunction

    always @(posedge clk) begin
        bit toIdle;
        edgeCnt++;
        toIdle = 1'b1;
        if (reset) begin
            expQ.delete();
            mLooping = 1'b0;
            mIdx     = 2'd0;
            armed    = 1'b1;
        end else if (!enable) begin
            expQ.delete();
            mLooping = 1'b0;
        end else if (song_next != song_prev) begin
            if (song_next) mIdx = (mIdx == 2'(NUM_SONGS - 1)) ? 2'd0 : mIdx + 2'd1;
            else           mIdx = (mIdx == 2'd0) ? 2'(NUM_SONGS - 1) : mIdx - 2'd1;
            expQ.delete();
            mLooping = 1'b0;
        end else if (play && !cur.busy && expQ.size() == 0 && !mLooping) begin
            mOct = 2'd0;
            repeat (2) expQ.push_back(mk(4'd0, 2'd0, 1'b1, mIdx, 0));
            buildNotes(mIdx);
        end else begin
            toIdle = 1'b0;
        end
        if (toIdle) begin
            cur = mk(4'd0, 2'd0, 1'b0, mIdx, 0);
        end else begin
            if (expQ.size() == 0 && mLooping) buildNotes(mIdx);
            if (expQ.size() > 0) cur = expQ.pop_front();
            else                 cur = mk(4'd0, 2'd0, 1'b0, mIdx, 0);
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        logic [6:0] expLed;
        logic [3:0] expNum;
        if (armed) begin
            expLed = (cur.note >= 4'd1 && cur.note <= 4'd7) ? (7'd1 << (cur.note - 4'd1)) : 7'd0;
            expNum = {2'b00, mIdx} + 4'd1;
            checks++;
            if (note_out !== cur.note || octave_out !== cur.oct || led_out !== expLed ||
                busy !== cur.busy || rom_addr !== cur.addr || num !== expNum) begin
                errors++;
                $display("[TB] FAIL model edge=%0d note=%0d/%0d oct=%0d/%0d led=%b/%b busy=%b/%b addr=%h/%h num=%0d/%0d (got/expected)",
                         edgeCnt, note_out, cur.note, octave_out, cur.oct, led_out, expLed,
                         busy, cur.busy, rom_addr, cur.addr, num, expNum);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s edge=%0d got=%0h expected=%0h", name, edgeCnt, act, exp);
        end
    endtask

    // One-cycle pulse; the edge that samples it becomes playEdge
    task automatic applyStimulus(input logic en, input logic p, input logic n, input logic pr);
        enable    = en;
        play      = p;
        song_next = n;
        song_prev = pr;
        playEdge  = edgeCnt + 1;
        @(negedge clk);
        enable    = 1'b1;
        play      = 1'b0;
        song_next = 1'b0;
        song_prev = 1'b0;
    endtask

    task automatic atEdge(input int t);
        while (edgeCnt < playEdge + t) @(negedge clk);
    endtask

    task automatic finishSong(input int bound);
`ifdef LOOP_EN
        repeat (bound) @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("loop_enable_drop_busy", 32'(busy), 32'd0);
`else
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", 32'(busy), 32'd0);
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) romMem[i] = {4'hF, 2'd0, 4'd0};
        // song 0: single note then END
        romMem[0]   = {4'd3, 2'd1, 4'd3};
        // song 1: dur 0 note, rest, silent code 9, si, END
        romMem[64]  = {4'd5, 2'd2, 4'd0};
        romMem[65]  = {4'd0, 2'd0, 4'd2};
        romMem[66]  = {4'd9, 2'd3, 4'd1};
        romMem[67]  = {4'd7, 2'd0, 4'd1};
        // song 2: 64 notes with no END marker
        for (int i = 0; i < 64; i++) romMem[128 + i] = {4'(i % 7 + 1), 2'(i % 4), 4'd1};

        repeat (3) @(negedge clk);
        reset  = 1'b0;
        enable = 1'b1;
        checkOutput("reset_num", 32'(num), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_addr", 32'(rom_addr), 32'd0);
        @(negedge clk);

        // single note on song 0
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("pending_busy", 32'(busy), 32'd0);
        atEdge(1);  checkOutput("fetch_busy", 32'(busy), 32'd1);
        atEdge(3);  checkOutput("n1_note", 32'(note_out), 32'd3);
                    checkOutput("n1_oct", 32'(octave_out), 32'd1);
                    checkOutput("n1_led", 32'(led_out), 32'b0000100);
        atEdge(26); checkOutput("n1_last_play", 32'(note_out), 32'd3);
        atEdge(27); checkOutput("n1_gap_note", 32'(note_out), 32'd0);
                    checkOutput("n1_gap_led", 32'(led_out), 32'd0);
        atEdge(32); checkOutput("n1_load_busy", 32'(busy), 32'd1);
`ifdef LOOP_EN
        atEdge(33); checkOutput("loop_busy", 32'(busy), 32'd1);
                    checkOutput("loop_addr", 32'(rom_addr), 32'h00);
        atEdge(35); checkOutput("loop_note", 32'(note_out), 32'd3);
`else
        atEdge(33); checkOutput("n1_end_busy", 32'(busy), 32'd0);
`endif
        finishSong(10);

        // song selection wrap-around
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1); checkOutput("wrap_prev_num", 32'(num), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1); checkOutput("both_num", 32'(num), 32'd3);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); checkOutput("wrap_next_num", 32'(num), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0); checkOutput("next_num", 32'(num), 32'd2);

        // song 1: dur 0, rest, silent code, si
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        atEdge(3);  checkOutput("d0_note", 32'(note_out), 32'd5);
                    checkOutput("d0_led", 32'(led_out), 32'b0010000);
        atEdge(10); checkOutput("d0_last", 32'(note_out), 32'd5);
        atEdge(11); checkOutput("d0_gap", 32'(note_out), 32'd0);
        atEdge(20); checkOutput("rest_busy", 32'(busy), 32'd1);
        play = 1'b1;
        @(negedge clk);
        play = 1'b0;
        atEdge(40); checkOutput("code9_oct", 32'(octave_out), 32'd3);
                    checkOutput("code9_note", 32'(note_out), 32'd0);
        atEdge(53); checkOutput("si_led", 32'(led_out), 32'b1000000);
        finishSong(100);

        // play with enable low is ignored
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("noenable_play_busy", 32'(busy), 32'd0);

        // abort by song change, then enable drop
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        atEdge(10);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_num", 32'(num), 32'd2);
        checkOutput("abort_addr", 32'(rom_addr), 32'h40);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        atEdge(1);  checkOutput("abort_refetch", 32'(rom_addr), 32'h40);
        atEdge(20);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("endrop_busy", 32'(busy), 32'd0);
        checkOutput("endrop_num", 32'(num), 32'd2);

        // reset in the middle of PLAY
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        atEdge(5);  checkOutput("s2_first_note", 32'(note_out), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_note", 32'(note_out), 32'd0);
        checkOutput("rst_led", 32'(led_out), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_num", 32'(num), 32'd1);
        checkOutput("rst_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // implicit end of song 2 at the last address
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        atEdge(896); checkOutput("last_gap_addr", 32'(rom_addr), 32'hBF);
                     checkOutput("last_gap_busy", 32'(busy), 32'd1);
`ifdef LOOP_EN
        atEdge(897); checkOutput("wrap_loop_addr", 32'(rom_addr), 32'h80);
                     checkOutput("wrap_loop_busy", 32'(busy), 32'd1);
`else
        atEdge(897); checkOutput("implicit_end_busy", 32'(busy), 32'd0);
                     checkOutput("implicit_end_addr", 32'(rom_addr), 32'h80);
`endif
        finishSong(20);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
